// File: rtl/snitch_icache_refill_assembler.sv
// snitch_icache_refill_assembler
// Refill back-end of the instruction cache: forwards line refill requests to
// memory as fixed-length bursts, tracks their IDs in an in-order FIFO and
// assembles the returning memory beats into full cache lines.
// Optional feature macro: SNITCH_ICACHE_REFILL_PERF_EN (completed refill counter).
module snitch_icache_refill_assembler #(
    parameter int unsigned FETCH_AW        = 48,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned MEM_DW          = 32,
    parameter int unsigned PENDING_IW      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [FETCH_AW-1:0]   in_req_addr_i,
    input  logic [PENDING_IW-1:0] in_req_id_i,
    input  logic                  in_req_valid_i,
    output logic                  in_req_ready_o,

    output logic [LINE_WIDTH-1:0] out_rsp_data_o,
    output logic                  out_rsp_error_o,
    output logic [PENDING_IW-1:0] out_rsp_id_o,
    output logic                  out_rsp_valid_o,
    input  logic                  out_rsp_ready_i,

    output logic [FETCH_AW-1:0]   mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,

    input  logic [MEM_DW-1:0]     mem_rsp_data_i,
    input  logic                  mem_rsp_error_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,

    output logic [31:0]           refill_cnt_o
);

    localparam int unsigned BEATS = LINE_WIDTH / MEM_DW;
    localparam int unsigned OFFS  = $clog2(LINE_WIDTH / 8);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW    = PW + 1;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        OUTPUT   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [LINE_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;

    logic [PENDING_IW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PENDING_IW-1:0]   fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    out_hs;

    // Line offset bits are dropped from the burst base address.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^in_req_addr_i[OFFS-1:0];

    assign mem_req_addr_o = {in_req_addr_i[FETCH_AW-1:OFFS], {OFFS{1'b0}}};
    assign mem_req_len_o  = 8'(BEATS - 1);

    assign out_rsp_data_o  = data_q;
    assign out_rsp_error_o = err_q;
    assign out_rsp_id_o    = fifo_q[rptr_q];
    assign out_hs          = out_rsp_valid_o && out_rsp_ready_i;

    // Request pass-through and in-flight ID FIFO bookkeeping.
    always_comb begin
        full            = (cnt_q == CW'(MAX_OUTSTANDING));
        in_req_ready_o  = mem_req_ready_i && !full;
        mem_req_valid_o = in_req_valid_i && !full;
        push            = in_req_valid_i && in_req_ready_o;
        // Guarded so a line produced from stray beats cannot underflow the count.
        pop             = out_hs && (cnt_q != '0);

        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            fifo_d[wptr_q] = in_req_id_i;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Response FSM: gather BEATS beats, then present the line until taken.
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        data_d          = data_q;
        err_d           = err_q;
        mem_rsp_ready_o = 1'b0;
        out_rsp_valid_o = 1'b0;

        unique case (state_q)
            ASSEMBLE: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    data_d[int'(beat_cnt_q) * MEM_DW +: MEM_DW] = mem_rsp_data_i;
                    err_d = err_q | mem_rsp_error_i;
                    if (beat_cnt_q == BW'(BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = OUTPUT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                out_rsp_valid_o = 1'b1;
                if (out_rsp_ready_i) begin
                    err_d   = 1'b0;
                    state_d = ASSEMBLE;
                end
            end
            default: begin
                state_d = ASSEMBLE;
            end
        endcase
    end

    // State, line buffer and FIFO registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ASSEMBLE;
            beat_cnt_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            fifo_q     <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    logic [31:0] refill_cnt_q, refill_cnt_d;

    // Completed refill counter, wraps naturally at 2^32.
    always_comb begin
        refill_cnt_d = refill_cnt_q;
        if (out_hs) begin
            refill_cnt_d = refill_cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refill_cnt_q <= '0;
        end else begin
            refill_cnt_q <= refill_cnt_d;
        end
    end

    assign refill_cnt_o = refill_cnt_q;
`else
    assign refill_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // Memory beats must belong to an outstanding burst.
    beat_without_request : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (mem_rsp_valid_i && mem_rsp_ready_o) |-> (cnt_q != '0)
    ) else $error("memory beat accepted with no outstanding refill");
`endif

endmodule

// File: tb/tb_snitch_icache_refill_assembler.sv
// Testbench for snitch_icache_refill_assembler: directed refills checked every
// cycle against a line-level model, plus literal expectations from the test plan.
module tb_snitch_icache_refill_assembler;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [47:0]  in_req_addr_i = '0;
    logic [1:0]   in_req_id_i = '0;
    logic         in_req_valid_i = 1'b0;
    logic         in_req_ready_o;
    logic [127:0] out_rsp_data_o;
    logic         out_rsp_error_o;
    logic [1:0]   out_rsp_id_o;
    logic         out_rsp_valid_o;
    logic         out_rsp_ready_i = 1'b1;
    logic [47:0]  mem_req_addr_o;
    logic [7:0]   mem_req_len_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b1;
    logic [31:0]  mem_rsp_data_i = '0;
    logic         mem_rsp_error_i = 1'b0;
    logic         mem_rsp_valid_i = 1'b0;
    logic         mem_rsp_ready_o;
    logic [31:0]  refill_cnt_o;

    snitch_icache_refill_assembler #(
        .FETCH_AW(48), .LINE_WIDTH(128), .MEM_DW(32), .PENDING_IW(2), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_req_addr_i(in_req_addr_i), .in_req_id_i(in_req_id_i),
        .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
        .out_rsp_data_o(out_rsp_data_o), .out_rsp_error_o(out_rsp_error_o),
        .out_rsp_id_o(out_rsp_id_o), .out_rsp_valid_o(out_rsp_valid_o),
        .out_rsp_ready_i(out_rsp_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .refill_cnt_o(refill_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- line-level model ----------------
    typedef struct packed {
        logic [127:0] data;
        logic         err;
        logic [1:0]   id;
    } line_t;

    line_t        lines[$];      // completed lines awaiting handoff
    logic [1:0]   ids[$];        // accepted request IDs not yet bound to a line
    int unsigned  outstanding;   // accepted requests not yet returned
    logic [127:0] part;
    logic         part_err;
    int unsigned  nbeats;
    logic [31:0]  refills;

    function automatic logic [31:0] exp_cnt();
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
        return refills;
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            lines.delete();
            ids.delete();
            outstanding = 0;
            part = '0;
            part_err = 1'b0;
            nbeats = 0;
            refills = '0;
            chk("rst_out_valid", out_rsp_valid_o, 0);
            chk("rst_out_error", out_rsp_error_o, 0);
            chk("rst_out_data", out_rsp_data_o, 0);
            chk("rst_mem_rsp_ready", mem_rsp_ready_o, 1);
            chk("rst_refill_cnt", refill_cnt_o, 0);
        end else begin
            automatic bit full_m = (outstanding >= 4);
            automatic bit have_line = (lines.size() != 0);
            chk("in_req_ready", in_req_ready_o, mem_req_ready_i && !full_m);
            chk("mem_req_valid", mem_req_valid_o, in_req_valid_i && !full_m);
            chk("mem_req_addr", mem_req_addr_o, in_req_addr_i & ~48'hF);
            chk("mem_req_len", mem_req_len_o, 8'd3);
            chk("out_rsp_valid", out_rsp_valid_o, have_line);
            chk("mem_rsp_ready", mem_rsp_ready_o, !have_line);
            chk("refill_cnt", refill_cnt_o, exp_cnt());
            if (have_line) begin
                chk("out_rsp_data", out_rsp_data_o, lines[0].data);
                chk("out_rsp_error", out_rsp_error_o, lines[0].err);
                chk("out_rsp_id", out_rsp_id_o, lines[0].id);
            end
            // Events taking effect at the coming rising edge.
            if (in_req_valid_i && mem_req_ready_i && !full_m) begin
                ids.push_back(in_req_id_i);
                outstanding++;
            end
            if (have_line && out_rsp_ready_i) begin
                void'(lines.pop_front());
                outstanding--;
                refills = refills + 32'd1;
            end
            if (!have_line && mem_rsp_valid_i) begin
                part[nbeats*32 +: 32] = mem_rsp_data_i;
                part_err = part_err | mem_rsp_error_i;
                nbeats++;
                if (nbeats == 4) begin
                    automatic line_t l;
                    l.data = part;
                    l.err  = part_err;
                    l.id   = (ids.size() != 0) ? ids.pop_front() : 2'b00;
                    lines.push_back(l);
                    nbeats = 0;
                    part_err = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [47:0] addr, input logic [1:0] id);
        bit ok = 0;
        in_req_valid_i = 1'b1;
        in_req_addr_i  = addr;
        in_req_id_i    = id;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (in_req_ready_o) begin ok = 1; break; end
        end
        chk("req_accept_timeout", ok, 1);
        step();
        in_req_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic e);
        bit ok = 0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        mem_rsp_error_i = e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (mem_rsp_ready_o) begin ok = 1; break; end
        end
        chk("beat_accept_timeout", ok, 1);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_error_i = 1'b0;
    endtask

    task automatic burst(input logic [31:0] base, input logic [3:0] errs);
        for (int i = 0; i < 4; i++) beat(base + 32'(i + 1) * 32'h11, errs[i]);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        step();
        rst_i = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        do_reset();

        // Single refill, literal address/length/line.
        in_req_valid_i = 1'b1;
        in_req_addr_i  = 48'h1234;
        in_req_id_i    = 2'd2;
        @(negedge clk_i);
        chk("lit_addr", mem_req_addr_o, 48'h1230);
        chk("lit_len", mem_req_len_o, 8'd3);
        chk("lit_req_ready", in_req_ready_o, 1);
        step();
        in_req_valid_i = 1'b0;
        burst(32'h0, 4'b0000);
        @(negedge clk_i);
        chk("lit_line_valid", out_rsp_valid_o, 1);
        chk("lit_line_data", out_rsp_data_o, 128'h00000044_00000033_00000022_00000011);
        chk("lit_line_id", out_rsp_id_o, 2'd2);
        chk("lit_line_err", out_rsp_error_o, 0);
        step();

        // Error on beat 1 only, then a clean line.
        req(48'h2000, 2'd1);
        burst(32'h100, 4'b0010);
        @(negedge clk_i);
        chk("lit_err_line", out_rsp_error_o, 1);
        step();
        req(48'h2040, 2'd3);
        burst(32'h200, 4'b0000);
        @(negedge clk_i);
        chk("lit_err_cleared", out_rsp_error_o, 0);
        chk("lit_err_cleared_id", out_rsp_id_o, 2'd3);
        step();

        // Fill the ID FIFO; fifth request blocked until first handshake.
        for (int i = 0; i < 4; i++) req(48'h3000 + 48'(i) * 48'h10, 2'(i));
        in_req_valid_i = 1'b1;
        in_req_addr_i  = 48'h4008;
        in_req_id_i    = 2'd2;
        @(negedge clk_i);
        chk("lit_full_ready", in_req_ready_o, 0);
        chk("lit_full_valid", mem_req_valid_o, 0);
        step();
        burst(32'h300, 4'b0000);
        @(negedge clk_i);
        chk("lit_full_id0", out_rsp_id_o, 2'd0);
        chk("lit_full_still", in_req_ready_o, 0);
        step();
        @(negedge clk_i);
        chk("lit_unblocked", in_req_ready_o, 1);
        step();
        in_req_valid_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            burst(32'h400 + 32'(i) * 32'h100, 4'b0000);
            @(negedge clk_i);
            chk("lit_order_id", out_rsp_id_o, (i == 4) ? 2'd2 : 2'(i));
            step();
        end

        // Back-pressure: hold the line for 5 cycles.
        req(48'h5000, 2'd1);
        req(48'h5010, 2'd3);
        out_rsp_ready_i = 1'b0;
        burst(32'hA00, 4'b0000);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hB0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("lit_hold_mem_ready", mem_rsp_ready_o, 0);
            chk("lit_hold_data", out_rsp_data_o,
                128'h00000A44_00000A33_00000A22_00000A11);
            chk("lit_hold_id", out_rsp_id_o, 2'd1);
            step();
        end
        out_rsp_ready_i = 1'b1;
        burst(32'hB00, 4'b0000);
        @(negedge clk_i);
        chk("lit_after_hold_id", out_rsp_id_o, 2'd3);
        step();

        // Reset in the middle of a burst.
        req(48'h6000, 2'd2);
        beat(32'hDEAD0000, 1'b1);
        beat(32'hDEAD0001, 1'b0);
        do_reset();
        @(negedge clk_i);
        chk("lit_post_rst_valid", out_rsp_valid_o, 0);
        chk("lit_post_rst_ready", in_req_ready_o, 1);
        step();
        req(48'h7000, 2'd1);
        burst(32'hC00, 4'b0000);
        @(negedge clk_i);
        chk("lit_fresh_data", out_rsp_data_o, 128'h00000C44_00000C33_00000C22_00000C11);
        chk("lit_fresh_id", out_rsp_id_o, 2'd1);
        chk("lit_fresh_err", out_rsp_error_o, 0);
        step();

        // Two more refills, then check the counter.
        for (int i = 0; i < 2; i++) begin
            req(48'h8000 + 48'(i) * 48'h10, 2'(i));
            burst(32'hD00 + 32'(i) * 32'h100, 4'b0000);
        end
        step();
        step();
        @(negedge clk_i);
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
        chk("lit_refill_cnt", refill_cnt_o, 32'd3);
`else
        chk("lit_refill_cnt", refill_cnt_o, 32'd0);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
